// File: rtl/ro_meas_ctrl.sv
// rtl/ro_meas_ctrl.sv - ring-oscillator measurement sequencer (settle, gated edge count, DONE/ACK)
// Optional saturating counter with sticky OVF when RO_MEAS_CTRL_SAT_EN is defined.
module ro_meas_ctrl #(
  parameter int CNT_W         = 16,
  parameter int GATE_W        = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              START,
  input  logic              ACK,
  input  logic [1:0]        SEL,
  input  logic [GATE_W-1:0] GATE_LEN,
  input  logic [3:0]        RO_OUT,
  output logic [3:0]        RO_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVF
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = (GATE_W > SW) ? GATE_W : SW;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GATE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [1:0]        sel_q, sel_d;
  logic [GATE_W-1:0] glen_q, glen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sync1_q, sync2_q, prev_q;
  logic              pulse;
`ifdef RO_MEAS_CTRL_SAT_EN
  logic              ovf_q, ovf_d;
`endif

  assign pulse = sync2_q & ~prev_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sel_d   = sel_q;
    glen_d  = glen_q;
    cnt_d   = cnt_q;
`ifdef RO_MEAS_CTRL_SAT_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          sel_d   = SEL;
          // gate length is stored minus one so it loads straight into the down-counter
          glen_d  = (GATE_LEN == '0) ? '0 : GATE_LEN - 1'b1;
          cnt_d   = '0;
`ifdef RO_MEAS_CTRL_SAT_EN
          ovf_d   = 1'b0;
`endif
          tmr_d   = TW'(SETTLE_CYCLES - 1);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr_q == '0) begin
          tmr_d   = TW'(glen_q);
          state_d = S_GATE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_GATE: begin
        if (pulse) begin
`ifdef RO_MEAS_CTRL_SAT_EN
          if (&cnt_q) ovf_d = 1'b1;
          else        cnt_d = cnt_q + 1'b1;
`else
          cnt_d = cnt_q + 1'b1;
`endif
        end
        if (tmr_q == '0) state_d = S_DONE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      S_DONE: begin
        if (ACK) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      sel_q   <= '0;
      glen_q  <= '0;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
`ifdef RO_MEAS_CTRL_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sel_q   <= sel_d;
      glen_q  <= glen_d;
      cnt_q   <= cnt_d;
      sync1_q <= RO_OUT[sel_q];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
`ifdef RO_MEAS_CTRL_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign BUSY  = (state_q == S_SETTLE) || (state_q == S_GATE);
  assign DONE  = (state_q == S_DONE);
  assign RO_EN = BUSY ? (4'b0001 << sel_q) : 4'b0000;
  assign COUNT = cnt_q;
`ifdef RO_MEAS_CTRL_SAT_EN
  assign OVF   = ovf_q;
`else
  assign OVF   = 1'b0;
`endif

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// tb/tb_ro_meas_ctrl.sv - self-checking bench for ro_meas_ctrl (16-bit and 4-bit counter instances)
// Expected counts come from vector tables and an edge-window reference model over the logged RO inputs.
module tb_ro_meas_ctrl;

  localparam int S = 8;

  logic        CLK = 1'b0;
  logic        RN = 1'b0;
  logic        START = 1'b0;
  logic        ACK = 1'b0;
  logic [1:0]  SEL = 2'd0;
  logic [15:0] GATE_LEN = 16'd0;
  logic [3:0]  RO_OUT = 4'b0000;

  logic [3:0]  ro_en, ro_en_s;
  logic        busy, busy_s, done, done_s, ovf, ovf_s;
  logic [15:0] count;
  logic [3:0]  count_s;

  ro_meas_ctrl #(.CNT_W(16), .GATE_W(16), .SETTLE_CYCLES(S)) u_dut (
    .CLK(CLK), .RN(RN), .START(START), .ACK(ACK), .SEL(SEL), .GATE_LEN(GATE_LEN),
    .RO_OUT(RO_OUT), .RO_EN(ro_en), .BUSY(busy), .DONE(done), .COUNT(count), .OVF(ovf)
  );

  ro_meas_ctrl #(.CNT_W(4), .GATE_W(16), .SETTLE_CYCLES(S)) u_small (
    .CLK(CLK), .RN(RN), .START(START), .ACK(ACK), .SEL(SEL), .GATE_LEN(GATE_LEN),
    .RO_OUT(RO_OUT), .RO_EN(ro_en_s), .BUSY(busy_s), .DONE(done_s), .COUNT(count_s), .OVF(ovf_s)
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int edge_n   = 0;
  logic [3:0] ro_log [0:8191];

  int half [4] = '{0, 0, 0, 0};
  int ctr  [4] = '{0, 0, 0, 0};
  bit rnd_mode = 1'b0;

  // ring waveform generator; changes land on the falling edge, away from sampling
  always @(negedge CLK) begin
    for (int r = 0; r < 4; r++) begin
      if (half[r] == 0) begin
        RO_OUT[r] = 1'b0;
      end else if (ctr[r] <= 1) begin
        RO_OUT[r] = ~RO_OUT[r];
        ctr[r] = rnd_mode ? int'($urandom_range(2, 6)) : half[r];
      end else begin
        ctr[r] = ctr[r] - 1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    edge_n = edge_n + 1;
    if (edge_n > 8191) begin
      $display("FAIL cycle_budget: edge %0d exceeds log size 8191", edge_n);
      $fatal(1);
    end
    ro_log[edge_n] = RO_OUT;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (act === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // rising edges of the selected ring whose detect pulse lands inside the gate window
  function automatic int model_edges(int s, int se, int g);
    int ge = (g == 0) ? 1 : g;
    int n = 0;
    for (int k = se + S - 1; k <= se + S + ge - 2; k++)
      if (ro_log[k][s] && !ro_log[k-1][s]) n++;
    return n;
  endfunction

  function automatic int small_count(int n);
`ifdef RO_MEAS_CTRL_SAT_EN
    return (n > 15) ? 15 : n;
`else
    return n % 16;
`endif
  endfunction

  function automatic int small_ovf(int n);
`ifdef RO_MEAS_CTRL_SAT_EN
    return (n > 15) ? 1 : 0;
`else
    return (n < 0) ? 1 : 0;
`endif
  endfunction

  // issue START, check enable, wait (bounded) for DONE, check its timing
  task automatic measure(input logic [1:0] s, input logic [15:0] g, output int se);
    int de = -1;
    int d  = S + ((g == 0) ? 1 : int'(g));
    SEL = s; GATE_LEN = g; START = 1'b1;
    tick();
    se = edge_n;
    START = 1'b0;
    chk("ro_en_on", 32'(ro_en), 32'(4'b0001 << s));
    chk("busy_on", 32'(busy), 32'd1);
    for (int i = 0; i < d + 20 && de < 0; i++) begin
      tick();
      if (done) de = edge_n;
    end
    chk("done_latency", 32'(de - se), 32'(d));
    chk("done_ro_en_off", 32'(ro_en), 32'd0);
  endtask

  task automatic ack_it();
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    chk("ack_done_low", 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] glen;
    int          half;
    int          exp_n;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int se, n, cnt_save, bad;

    vecs[0] = '{2'd2, 16'd64,  4, 8};
    vecs[1] = '{2'd1, 16'd0,   0, 0};
    vecs[2] = '{2'd1, 16'd32,  4, 4};
    vecs[3] = '{2'd3, 16'd48,  2, 12};
    vecs[4] = '{2'd0, 16'd16,  8, 1};
    vecs[5] = '{2'd0, 16'd100, 2, 25};

    // reset held with START high and rings toggling
    half = '{1, 2, 3, 1};
    START = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_ro_en", 32'(ro_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    START = 1'b0; RN = 1'b1;
    tick(); tick();
    chk("idle_after_rst", 32'({busy, done, ro_en}), 32'd0);

    // ACK in IDLE has no effect
    ACK = 1'b1; tick(); ACK = 1'b0;
    chk("ack_idle", 32'({busy, done, ro_en}), 32'd0);

    for (int v = 0; v < 6; v++) begin
      for (int r = 0; r < 4; r++) half[r] = (r == int'(vecs[v].sel)) ? vecs[v].half : 1;
      for (int i = 0; i < 8; i++) tick();
      measure(vecs[v].sel, vecs[v].glen, se);
      chk($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].exp_n));
      chk($sformatf("vec%0d_ovf", v), 32'(ovf), 32'd0);
      chk($sformatf("vec%0d_small_count", v), 32'(count_s), 32'(small_count(vecs[v].exp_n)));
      chk($sformatf("vec%0d_small_ovf", v), 32'(ovf_s), 32'(small_ovf(vecs[v].exp_n)));
      ack_it();
    end

    // DONE held without ACK; START ignored in DONE
    half = '{3, 3, 3, 3};
    measure(2'd1, 16'd20, se);
    cnt_save = int'(count);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!done || int'(count) != cnt_save) bad++;
    end
    chk("done_hold_stable", 32'(bad), 32'd0);
    START = 1'b1; tick(); START = 1'b0;
    chk("start_in_done", 32'({busy, done}), 32'd1);
    chk("start_in_done_count", 32'(count), 32'(cnt_save));
    ack_it();
    chk("ack_busy_low", 32'(busy), 32'd0);

    // START pulse and SEL change mid-GATE ignored: one measurement, original ring
    half = '{2, 3, 1, 5};
    SEL = 2'd3; GATE_LEN = 16'd30; START = 1'b1;
    tick();
    se = edge_n;
    START = 1'b0;
    for (int i = 0; i < S + 5; i++) tick();
    SEL = 2'd0; GATE_LEN = 16'd2; START = 1'b1;
    tick();
    START = 1'b0;
    chk("sel_change_ro_en", 32'(ro_en), 32'b1000);
    bad = -1;
    for (int i = 0; i < 40 && bad < 0; i++) begin
      tick();
      if (done) bad = edge_n;
    end
    chk("ignored_start_latency", 32'(bad - se), 32'(S + 30));
    chk("ignored_start_count", 32'(count), 32'(model_edges(3, se, 30)));
    ack_it();
    tick(); tick();
    chk("single_done", 32'({busy, done}), 32'd0);

    // reset mid-GATE aborts
    measure(2'd2, 16'd10, se);
    ack_it();
    SEL = 2'd2; GATE_LEN = 16'd200; START = 1'b1;
    tick(); START = 1'b0;
    for (int i = 0; i < S + 30; i++) tick();
    RN = 1'b0; tick(); RN = 1'b1;
    chk("abort_ro_en", 32'(ro_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick(); tick();
    chk("abort_idle", 32'({busy, done}), 32'd0);

    // randomized measurements against the edge-window model
    rnd_mode = 1'b1;
    half = '{1, 1, 1, 1};
    for (int it = 0; it < 10; it++) begin
      logic [1:0]  rs;
      logic [15:0] rg;
      rs = 2'($urandom_range(0, 3));
      rg = 16'($urandom_range(0, 60));
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) tick();
      measure(rs, rg, se);
      n = model_edges(int'(rs), se, int'(rg));
      chk($sformatf("rnd%0d_count", it), 32'(count), 32'(n));
      chk($sformatf("rnd%0d_small_count", it), 32'(count_s), 32'(small_count(n)));
      chk($sformatf("rnd%0d_small_ovf", it), 32'(ovf_s), 32'(small_ovf(n)));
      ack_it();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
